// File: rtl/onchip_mem_pkg.sv
// onchip_mem_pkg: shared size defaults and requester IDs for the on-chip memory arbiter
package onchip_mem_pkg;
   localparam int ADDR_W_DEF    = 13;
   localparam int DATA_W_DEF    = 32;
   localparam int MEM_DEPTH_DEF = 4942;
   typedef enum logic {ID_M0 = 1'b0, ID_M1 = 1'b1} req_id_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant with last-grant state
module rr_arb2
   import onchip_mem_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req_i,
   output logic       gnt_valid_o,
   output req_id_t    gnt_id_o
);
   req_id_t last_q, last_d;
   // grant the lone requester, or the one not granted last when both ask
   always_comb begin
      gnt_valid_o = |req_i;
      gnt_id_o    = (&req_i) ? ((last_q == ID_M0) ? ID_M1 : ID_M0) : (req_i[1] ? ID_M1 : ID_M0);
      last_d      = gnt_valid_o ? gnt_id_o : last_q;
   end
   // last grant starts as m1 so m0 wins the first contention; idle cycles leave it alone
   always_ff @(posedge clk) begin
      last_q <= reset ? ID_M1 : last_d;
   end
endmodule

// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: two requesters sharing one single-cycle-latency memory port
module onchip_mem_arbiter
   import onchip_mem_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [ADDR_W-1:0]   m0_address,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   input  logic                m0_read,
   input  logic                m0_write,
   input  logic [DATA_W-1:0]   m0_writedata,
   output logic                m0_waitrequest,
   output logic [DATA_W-1:0]   m0_readdata,
   output logic                m0_readdatavalid,
   input  logic [ADDR_W-1:0]   m1_address,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic [DATA_W-1:0]   m1_writedata,
   output logic                m1_waitrequest,
   output logic [DATA_W-1:0]   m1_readdata,
   output logic                m1_readdatavalid,
   output logic                err_oor,
   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W/8-1:0] mem_byteenable,
   output logic                mem_chipselect,
   output logic                mem_write,
   output logic [DATA_W-1:0]   mem_writedata,
   input  logic [DATA_W-1:0]   mem_readdata
);
   localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);
   logic        gnt_valid, sel_wr, sel_oor;
   req_id_t     gnt_id, rd_id_q;
   logic        rd_valid_q, rd_valid_d, rd_oor_q, err_oor_q, err_oor_d;
   logic [DATA_W-1:0] rd_data;
   rr_arb2 u_arb (
      .clk         (clk),
      .reset       (reset),
      .req_i       ({m1_read | m1_write, m0_read | m0_write}),
      .gnt_valid_o (gnt_valid),
      .gnt_id_o    (gnt_id)
   );
   // steer the granted command to memory; out-of-range commands are accepted but never reach it
   always_comb begin
      mem_address    = (gnt_id == ID_M1) ? m1_address    : m0_address;
      mem_byteenable = (gnt_id == ID_M1) ? m1_byteenable : m0_byteenable;
      mem_writedata  = (gnt_id == ID_M1) ? m1_writedata  : m0_writedata;
      sel_wr         = (gnt_id == ID_M1) ? m1_write      : m0_write;
      sel_oor        = {1'b0, mem_address} >= DEPTH;
      mem_chipselect = gnt_valid & ~sel_oor;
      mem_write      = mem_chipselect & sel_wr;
      m0_waitrequest = ~(gnt_valid & (gnt_id == ID_M0));
      m1_waitrequest = ~(gnt_valid & (gnt_id == ID_M1));
      rd_valid_d     = gnt_valid & ~sel_wr;
      err_oor_d      = err_oor_q | (gnt_valid & sel_oor);
   end
   // read-response slice tracks who issued the read and whether it was out of range
   always_ff @(posedge clk) begin
      rd_valid_q <= ~reset & rd_valid_d;
      rd_id_q    <= gnt_id;
      rd_oor_q   <= sel_oor;
      err_oor_q  <= ~reset & err_oor_d;
   end
   // route the response; reset masks a response already in flight
   always_comb begin
      rd_data          = rd_oor_q ? '0 : mem_readdata;
      m0_readdata      = rd_data;
      m1_readdata      = rd_data;
      m0_readdatavalid = rd_valid_q & ~reset & (rd_id_q == ID_M0);
      m1_readdatavalid = rd_valid_q & ~reset & (rd_id_q == ID_M1);
   end
   assign err_oor = err_oor_q;
endmodule
